// File: rtl/pong_pkg.sv
// Shared types and BCD helpers for the pong score keeper.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } score_state_t;

    typedef logic [7:0] bcd2_t;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v[3:0] != 4'd9) begin
            r = {v[7:4], v[3:0] + 4'd1};
        end else if (v[7:4] != 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    function automatic bcd2_t to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter with synchronous clear (clear wins over increment).
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] count_o
);

    bcd2_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'h00;
        end else if (inc_i) begin
            count_d = bcd_inc(count_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/config.svh
// Screen geometry shared by the game logic and the score keeper.
// Goal thresholds are sized to the ball position width so comparisons stay width-clean.
`ifndef PONG_CONFIG_SVH
`define PONG_CONFIG_SVH

`define X_POS_W       10
`define SCREEN_BORDER 10'd8
`define SCREEN_H_RES  10'd640

`endif

// File: rtl/score_keeper.sv
// Pong score keeper: goal detection, BCD scores, SERVE/PLAY/OVER sequencing.
// SCORE_SERVE_PAUSE_EN builds the serve pause counter; otherwise SERVE lasts one cycle.
`include "config.svh"

module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                new_frame_i,
    input  logic [`X_POS_W-1:0] ball_x_i,
    input  logic                restart_i,
    output logic [7:0]          player_score_o,
    output logic [7:0]          enemy_score_o,
    output logic                serve_hold_o,
    output logic                score_evt_o,
    output logic                game_over_o,
    output logic                winner_o,
    output logic [1:0]          state_o
);

    localparam bcd2_t WIN_BCD = to_bcd(WIN_SCORE);

    score_state_t state_q, state_d;
    logic  armed_q, armed_d, winner_q, winner_d, evt_q, evt_d, restart_q;
    logic  serve_done, sample, player_goal, enemy_goal, scoring;
    logic  player_pt, enemy_pt, point, win_hit, restart_rise, clr_scores;
    bcd2_t player_score, enemy_score;

`ifdef SCORE_SERVE_PAUSE_EN
    logic [7:0] cnt_q, cnt_d;

    // Held at SERVE_FRAMES outside SERVE so every entry starts from a full count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != SERVE) begin
            cnt_d = 8'(SERVE_FRAMES);
        end else if (new_frame_i && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'(SERVE_FRAMES);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign serve_done = (cnt_q == 8'd0);
`else
    localparam int serve_frames_unused = SERVE_FRAMES;
    assign serve_done = 1'b1;
`endif

    // A strobe landing on the serve-to-play transition is discarded entirely.
    assign sample       = new_frame_i && !(state_q == SERVE && serve_done);
    assign player_goal  = (ball_x_i < `SCREEN_BORDER);
    assign enemy_goal   = (ball_x_i > `SCREEN_H_RES);
    assign scoring      = sample && armed_q && (state_q == PLAY);
    assign player_pt    = scoring && player_goal;
    assign enemy_pt     = scoring && enemy_goal;
    assign point        = player_pt || enemy_pt;
    assign win_hit      = (player_pt && (bcd_inc(player_score) == WIN_BCD)) ||
                          (enemy_pt  && (bcd_inc(enemy_score)  == WIN_BCD));
    assign restart_rise = restart_i && !restart_q;
    assign clr_scores   = (state_q == OVER) && restart_rise;

    bcd2_counter u_player (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (player_pt),
        .clr_i   (clr_scores),
        .count_o (player_score)
    );

    bcd2_counter u_enemy (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (enemy_pt),
        .clr_i   (clr_scores),
        .count_o (enemy_score)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SERVE:   if (serve_done) state_d = PLAY;
            PLAY:    if (point) state_d = win_hit ? OVER : SERVE;
            OVER:    if (restart_rise) state_d = SERVE;
            default: state_d = SERVE;
        endcase
    end

    always_comb begin
        game_over_o = (state_q == OVER);
`ifdef SCORE_SERVE_PAUSE_EN
        serve_hold_o = (state_q != PLAY);
`else
        serve_hold_o = (state_q == OVER);
`endif
    end

    // Armed drops on a scored goal and returns on the next in-bounds sample.
    always_comb begin
        armed_d = armed_q;
        if (sample) begin
            if (!player_goal && !enemy_goal) begin
                armed_d = 1'b1;
            end else if (point) begin
                armed_d = 1'b0;
            end
        end
        winner_d = winner_q;
        if (win_hit) begin
            winner_d = player_pt;
        end
        evt_d = point;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q   <= 1'b1;
            winner_q  <= 1'b0;
            evt_q     <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            winner_q  <= winner_d;
            evt_q     <= evt_d;
            restart_q <= restart_i;
        end
    end

    assign player_score_o = player_score;
    assign enemy_score_o  = enemy_score;
    assign score_evt_o    = evt_q;
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule
